// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder over a word-wide synchronous RAM with byte strobes.
// Independent read and write channels, one outstanding transaction each.
//
// state   | meaning
// W_IDLE  | collecting AW and W in any order; both latched -> W_WRITE
// W_WRITE | RAM byte update (suppressed on DECERR), raise bvalid
// W_RESP  | hold bvalid/bresp until bready
// R_IDLE  | waiting for AR handshake
// R_READ  | phase 0: RAM read register loads; phase 1: rdata/rresp/rvalid load
// R_RESP  | hold rvalid/rdata/rresp until rready
module axi_lite_ram #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp
);
    localparam int WORDS = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

    w_state_t          w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_W-3:0] waddr_q, waddr_d;
    logic              werr_q, werr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              mem_we;

    r_state_t          r_state_q, r_state_d;
    logic              rphase_q, rphase_d;
    logic [ADDR_W-3:0] raddr_q, raddr_d;
    logic              rerr_q, rerr_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              ram_re;
    logic [31:0]       ram_rdata_q;

    logic [31:0]       mem [0:WORDS-1];

    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        waddr_d   = waddr_q;
        werr_d    = werr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid && awready_q) begin
                    aw_got_d = 1'b1;
                    waddr_d  = axi_awaddr[ADDR_W-1:2];
                    werr_d   = |axi_awaddr[31:ADDR_W];
                end
                if (axi_wvalid && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = axi_wdata;
                    wstrb_d = axi_wstrb;
                end
                // Readys also come up here on the first edge after reset.
                awready_d = !aw_got_d;
                wready_d  = !w_got_d;
                if (aw_got_q && w_got_q) w_state_d = W_WRITE;
            end
            W_WRITE: begin
                mem_we    = !werr_q;
                bvalid_d  = 1'b1;
                bresp_d   = werr_q ? 2'b11 : 2'b00;
                aw_got_d  = 1'b0;
                w_got_d   = 1'b0;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rphase_d  = rphase_q;
        raddr_d   = raddr_q;
        rerr_d    = rerr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid && arready_q) begin
                    raddr_d   = axi_araddr[ADDR_W-1:2];
                    rerr_d    = |axi_araddr[31:ADDR_W];
                    arready_d = 1'b0;
                    rphase_d  = 1'b0;
                    r_state_d = R_READ;
                end
            end
            R_READ: begin
                if (!rphase_q) begin
                    ram_re   = 1'b1;
                    rphase_d = 1'b1;
                end else begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rerr_q ? 32'h0 : ram_rdata_q;
                    rresp_d   = rerr_q ? 2'b11 : 2'b00;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            waddr_q   <= '0;
            werr_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
            rphase_q  <= 1'b0;
            raddr_q   <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            waddr_q   <= waddr_d;
            werr_q    <= werr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rphase_q  <= rphase_d;
            raddr_q   <= raddr_d;
            rerr_q    <= rerr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // RAM is not reset; a same-edge read sees the word before this edge's write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[waddr_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
        if (ram_re) ram_rdata_q <= mem[raddr_q];
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
endmodule
